// File: rtl/timer_tima.sv
// TIMA/TMA/TAC programmable timer.
// Counts falling edges of a selected divider tap, including DMG-style glitch edges.
// On overflow, TIMA holds 0x00 for OVF_DELAY clk1 cycles, then reloads from TMA
// and pulses int_timer for one cycle.
module timer_tima #(
  parameter int OVF_DELAY = 4
) (
  input  logic       clk1,
  input  logic       reset,
  inout  wire  [7:0] d,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic       ff04_ff07,
  input  logic       tovy_na0,
  input  logic       tola_na1,
  input  logic       tap_4096,
  input  logic       tap_262144,
  input  logic       tap_65536,
  input  logic       tap_16384,
  output logic       int_timer
);

  localparam int CNT_W = (OVF_DELAY > 2) ? $clog2(OVF_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OVF_DELAY - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } ovf_state_t;

  ovf_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_tima;
  logic [7:0]       r_tma;
  logic [2:0]       r_tac;
  logic             r_sig_q;
  logic             r_int;

  logic             w_sel_tima;
  logic             w_sel_tma;
  logic             w_sel_tac;
  logic             w_wr_tima;
  logic             w_wr_tma;
  logic             w_wr_tac;
  logic             w_rd_en;
  logic [7:0]       w_rd_data;
  logic             w_tap;
  logic             w_sig;
  logic             w_fall;
  logic             w_reload;

  // Register decode from the inverted address bits; FF04 (both high) is left to the divider.
  assign w_sel_tima = ff04_ff07 &  tola_na1 & ~tovy_na0;
  assign w_sel_tma  = ff04_ff07 & ~tola_na1 &  tovy_na0;
  assign w_sel_tac  = ff04_ff07 & ~tola_na1 & ~tovy_na0;

  assign w_wr_tima  = cpu_wr & w_sel_tima;
  assign w_wr_tma   = cpu_wr & w_sel_tma;
  assign w_wr_tac   = cpu_wr & w_sel_tac;
  assign w_rd_en    = cpu_rd & (w_sel_tima | w_sel_tma | w_sel_tac);

  // Any falling edge of the gated tap counts, including glitches from TAC writes or a divider reset.
  assign w_sig      = w_tap & r_tac[2];
  assign w_fall     = r_sig_q & ~w_sig;

  // The reload happens on the last cycle of the pending window.
  assign w_reload   = (r_state == ST_PEND) && (r_cnt == {CNT_W{1'b0}});

  assign int_timer  = r_int;
  assign d          = w_rd_en ? w_rd_data : 8'hzz;

  // Tap multiplexer selected by TAC[1:0].
  always_comb begin
    w_tap = 1'b0;
    case (r_tac[1:0])
      2'b00:   w_tap = tap_4096;
      2'b01:   w_tap = tap_262144;
      2'b10:   w_tap = tap_65536;
      2'b11:   w_tap = tap_16384;
      default: w_tap = 1'b0;
    endcase
  end

  // Read data for the addressed register; unused TAC bits read as ones.
  always_comb begin
    w_rd_data = 8'h00;
    if (w_sel_tima) begin
      w_rd_data = r_tima;
    end else if (w_sel_tma) begin
      w_rd_data = r_tma;
    end else if (w_sel_tac) begin
      w_rd_data = {5'b11111, r_tac};
    end else begin
      w_rd_data = 8'h00;
    end
  end

  // Timer state: register writes, counting, overflow countdown, reload and interrupt pulse.
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_tima  <= 8'h00;
      r_tma   <= 8'h00;
      r_tac   <= 3'b000;
      r_sig_q <= 1'b0;
      r_int   <= 1'b0;
    end else begin
      r_sig_q <= w_sig;
      r_int   <= 1'b0;

      if (w_wr_tac) begin
        r_tac <= d[2:0];
      end

      if (w_wr_tma) begin
        r_tma <= d;
      end

      if (w_reload) begin
        // A TMA write in this cycle bypasses straight into TIMA; TIMA writes are dropped.
        r_tima  <= w_wr_tma ? d : r_tma;
        r_int   <= 1'b1;
        r_state <= ST_IDLE;
        r_cnt   <= {CNT_W{1'b0}};
      end else if (w_wr_tima) begin
        // CPU write beats a same-cycle increment and cancels any pending reload.
        r_tima  <= d;
        r_state <= ST_IDLE;
        r_cnt   <= {CNT_W{1'b0}};
      end else begin
        case (r_state)
          ST_PEND: r_cnt <= r_cnt - CNT_W'(1);
          ST_IDLE: r_cnt <= {CNT_W{1'b0}};
          default: r_cnt <= {CNT_W{1'b0}};
        endcase
        if (w_fall) begin
          if (r_tima == 8'hFF) begin
            r_tima  <= 8'h00;
            r_state <= ST_PEND;
            r_cnt   <= CNT_LOAD;
          end else begin
            r_tima  <= r_tima + 8'd1;
          end
        end
      end
    end
  end

endmodule
